// File: rtl/prog_loader.sv
// Program-memory loader: parses a framed byte stream (header, count, hi/lo word
// bytes, XOR checksum), writes words into program memory and gates the core reset.
module prog_loader #(
  parameter logic [7:0] HEADER    = 8'hA5,
  parameter int         MAX_WORDS = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        cpu_rstn,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK, DONE, ERR} state_t;

  state_t      state, state_nxt;
  logic [5:0]  remaining, remaining_nxt;
  logic [4:0]  idx, idx_nxt;
  logic [7:0]  acc, acc_nxt;
  logic [7:0]  hi, hi_nxt;
  logic        wr_en_nxt;
  logic [4:0]  wr_addr_nxt;
  logic [15:0] wr_data_nxt;
  logic        cpu_rstn_nxt, done_nxt, err_nxt;
  logic        accept;

  assign accept = in_valid && in_ready;

  // Byte-accept stage: all outputs are flops, so cpu_rstn never glitches
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      remaining <= '0;
      idx       <= '0;
      acc       <= '0;
      hi        <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_rstn  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= 1'b1;
      remaining <= remaining_nxt;
      idx       <= idx_nxt;
      acc       <= acc_nxt;
      hi        <= hi_nxt;
      wr_en     <= wr_en_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
      cpu_rstn  <= cpu_rstn_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    idx_nxt       = idx;
    acc_nxt       = acc;
    hi_nxt        = hi;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    cpu_rstn_nxt  = cpu_rstn;
    done_nxt      = done;
    err_nxt       = err;
    if (accept) begin
      case (state)
        IDLE: begin
          if (in_data == HEADER) state_nxt = COUNT;
        end
        COUNT: begin
          if (in_data == 8'd0 || int'(in_data) > MAX_WORDS) begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end else begin
            remaining_nxt = in_data[5:0];
            idx_nxt       = '0;
            acc_nxt       = '0;
            state_nxt     = HI;
          end
        end
        HI: begin
          hi_nxt    = in_data;
          acc_nxt   = acc ^ in_data;
          state_nxt = LO;
        end
        LO: begin
          acc_nxt       = acc ^ in_data;
          wr_en_nxt     = 1'b1;
          wr_addr_nxt   = idx;
          wr_data_nxt   = {hi, in_data};
          idx_nxt       = idx + 5'd1;
          remaining_nxt = remaining - 6'd1;
          state_nxt     = (remaining == 6'd1) ? CHECK : HI;
        end
        CHECK: begin
          if (in_data == acc) begin
            state_nxt    = DONE;
            done_nxt     = 1'b1;
            cpu_rstn_nxt = 1'b1;
          end else begin
            state_nxt = ERR;
            err_nxt   = 1'b1;
          end
        end
        DONE, ERR: begin
          // A new header re-arms the loader and puts the core back into reset
          if (in_data == HEADER) begin
            state_nxt    = COUNT;
            done_nxt     = 1'b0;
            err_nxt      = 1'b0;
            cpu_rstn_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
